br_trace_recorder: RTL

BR_TRACE_RECORDER -- requirements
Module: br_trace_recorder

---
 rtl/br_trace_recorder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/br_trace_recorder.sv
// Branch trace recorder: captures resolved EX-stage branches into a
// first-word-fall-through FIFO during a recording run, with drop accounting.
module br_trace_recorder #(
  parameter int PC_LEN    = 32,
  parameter int INST_LEN  = 32,
  parameter int DEPTH     = 8,
  localparam int ENTRY_LEN = 2*PC_LEN + INST_LEN + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          limit,
  input  logic                 ex_valid,
  input  logic                 ex_is_br,
  input  logic [PC_LEN-1:0]    ex_pc,
  input  logic [INST_LEN-1:0]  ex_inst,
  input  logic                 ex_taken,
  input  logic [PC_LEN-1:0]    ex_target,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [ENTRY_LEN-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [15:0]          rec_count,
  output logic [15:0]          drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic [ENTRY_LEN-1:0]  r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [15:0]           r_limit;
  logic [15:0]           r_rec_count;
  logic [15:0]           r_drop_count;
  logic                  r_overflow;

  logic                  w_push_req;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_limit_hit;
  logic [AW:0]           w_count_next;
  logic [ENTRY_LEN-1:0]  w_entry;

  // Entry layout, LSB first: pc, instruction, taken bit, target.
  assign w_entry = {ex_target, ex_taken, ex_inst, ex_pc};

  assign w_push_req = (r_state == S_RECORD) && ex_valid && ex_is_br;
  assign w_pop      = rd_valid && rd_ready;
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  // A full FIFO can still take a push when the head leaves the same cycle.
  assign w_accept   = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_accept;

  assign w_count_next = r_count + (AW+1)'(w_accept) - (AW+1)'(w_pop);

  // Run ends when this cycle's accepted push brings the count to the limit.
  assign w_limit_hit = (r_limit != 16'd0) && w_accept &&
                       (({1'b0, r_rec_count} + 17'd1) >= {1'b0, r_limit});

  // Storage write; pointers decide visibility, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // FIFO pointers/occupancy, run counters and the recording state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_limit      <= '0;
      r_rec_count  <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;

      if (w_accept && (r_rec_count != 16'hFFFF)) r_rec_count <= r_rec_count + 16'd1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          // Arming a run clears its statistics but keeps buffered entries.
          if (start) begin
            r_state      <= S_RECORD;
            r_limit      <= limit;
            r_rec_count  <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
          end
        end
        S_RECORD: begin
          if (w_limit_hit) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_count_next == '0) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_valid   = (r_count != '0);
  assign rd_data    = rd_valid ? r_mem[r_rd_ptr] : '0;
  assign busy       = (r_state == S_RECORD);
  assign done       = (r_state == S_DONE);
  assign overflow   = r_overflow;
  assign rec_count  = r_rec_count;
  assign drop_count = r_drop_count;

endmodule
